// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB register-port target and related bus tooling.
// State encoding is exported on state_out, so keep the values stable.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        DEV_ADDR = 4'd1,
        DEV_ACK  = 4'd2,
        REG_HI   = 4'd3,
        ACK_HI   = 4'd4,
        REG_LO   = 4'd5,
        ACK_LO   = 4'd6,
        WR_DATA  = 4'd7,
        ACK_DATA = 4'd8,
        RD_DATA  = 4'd9,
        RD_ACK   = 4'd10,
        IGNORE   = 4'd11
    } sccb_tstate_t;

    localparam logic [6:0] OV5640_SCCB_ADDR = 7'h3C;
    localparam logic       SCCB_ACK         = 1'b0;
    localparam logic       SCCB_NACK        = 1'b1;

endpackage

// File: rtl/sccb_line_sync.sv
// SCL/SDA input synchronizers with one-cycle edge, START and STOP pulses.
// Reusable by anything that needs to observe the bus passively.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to the idle-bus level so leaving reset never fakes an edge or START.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/sccb_target.sv
// SCCB responder for an OV5640-style 16-bit register map: turns address+data
// writes into register-file strobes and serves auto-incrementing reads.
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR = OV5640_SCCB_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_o,
    output logic        sda_t,
    output logic        wr_valid,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic [3:0]  state_out
);

    sccb_tstate_t r_state;
    sccb_tstate_t w_state_next;
    logic [2:0]   r_bit_cnt;
    logic         r_phase_done;
    logic [7:0]   r_shift;
    logic [15:0]  r_ptr;
    logic         r_sda_t;
    logic         r_busy;
    logic         r_wr_valid;
    logic [15:0]  r_wr_addr;
    logic [7:0]   r_wr_data;

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;
    logic w_addr_match;
    logic w_rx_state;
    logic w_byte_end;
    logic w_sda_t_next;
    logic w_wr_fire;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .i_clk      (clk_in),
        .i_rst      (rst_in),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    // r_phase_done marks "8 bits seen" in byte states and "master ACKed" in RD_ACK.
    assign w_addr_match = (r_shift[7:1] == DEVICE_ADDR);
    assign w_rx_state   = (r_state == DEV_ADDR) || (r_state == REG_HI) ||
                          (r_state == REG_LO)   || (r_state == WR_DATA);
    assign w_byte_end   = w_scl_fall & r_phase_done;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_next = r_state;
        if (w_stop) begin
            w_state_next = IDLE;
        end else if (w_start) begin
            w_state_next = DEV_ADDR;
        end else begin
            case (r_state)
                DEV_ADDR: if (w_byte_end) w_state_next = w_addr_match ? DEV_ACK : IGNORE;
                DEV_ACK:  if (w_scl_fall) w_state_next = r_shift[0] ? RD_DATA : REG_HI;
                REG_HI:   if (w_byte_end) w_state_next = ACK_HI;
                ACK_HI:   if (w_scl_fall) w_state_next = REG_LO;
                REG_LO:   if (w_byte_end) w_state_next = ACK_LO;
                ACK_LO:   if (w_scl_fall) w_state_next = WR_DATA;
                WR_DATA:  if (w_byte_end) w_state_next = ACK_DATA;
                ACK_DATA: if (w_scl_fall) w_state_next = WR_DATA;
                RD_DATA:  if (w_byte_end) w_state_next = RD_ACK;
                RD_ACK: begin
                    if (w_scl_rise && w_sda == SCCB_NACK) w_state_next = IGNORE;
                    else if (w_byte_end)                  w_state_next = RD_DATA;
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    // SDA changes only on SCL falls; a 1 bit is sent by releasing the line.
    always_comb begin
        w_sda_t_next = r_sda_t;
        w_wr_fire    = (r_state == WR_DATA) && w_scl_rise && (r_bit_cnt == 3'd7);
        if (w_start || w_stop) begin
            w_sda_t_next = 1'b1;
        end else if (w_scl_fall) begin
            case (r_state)
                DEV_ADDR:                 if (r_phase_done) w_sda_t_next = ~w_addr_match;
                REG_HI, REG_LO, WR_DATA:  if (r_phase_done) w_sda_t_next = SCCB_ACK;
                DEV_ACK:                  w_sda_t_next = r_shift[0] ? rd_data[7] : 1'b1;
                RD_DATA:                  w_sda_t_next = r_phase_done ? 1'b1 : r_shift[6];
                RD_ACK:                   w_sda_t_next = r_phase_done ? rd_data[7] : 1'b1;
                default:                  w_sda_t_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_bit_cnt    <= '0;
            r_phase_done <= 1'b0;
            r_shift      <= '0;
            r_ptr        <= '0;
            r_sda_t      <= 1'b1;
            r_busy       <= 1'b0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every read sees pre-edge values.
            r_wr_valid <= 1'b0;
            r_sda_t    <= w_sda_t_next;

            if (w_stop) begin
                r_busy <= 1'b0;
            end else if (w_state_next == DEV_ACK && r_state != DEV_ACK) begin
                r_busy <= 1'b1;
            end

            if (w_start || w_stop) begin
                r_bit_cnt    <= '0;
                r_phase_done <= 1'b0;
            end else begin
                if (w_scl_rise && (w_rx_state || r_state == RD_DATA)) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) r_phase_done <= 1'b1;
                end
                if (w_scl_rise && w_rx_state) r_shift <= {r_shift[6:0], w_sda};
                if (w_byte_end) r_phase_done <= 1'b0;

                if (w_wr_fire) begin
                    r_wr_valid <= 1'b1;
                    r_wr_addr  <= r_ptr;
                    r_wr_data  <= {r_shift[6:0], w_sda};
                end

                case (r_state)
                    REG_HI:   if (w_byte_end) r_ptr[15:8] <= r_shift;
                    REG_LO:   if (w_byte_end) r_ptr[7:0]  <= r_shift;
                    ACK_DATA: if (w_scl_fall) r_ptr <= r_ptr + 16'd1;
                    DEV_ACK:  if (w_scl_fall && r_shift[0]) r_shift <= rd_data;
                    RD_DATA:  if (w_scl_fall && !r_phase_done) r_shift <= {r_shift[6:0], 1'b0};
                    RD_ACK: begin
                        if (w_scl_rise && w_sda == SCCB_ACK) begin
                            r_ptr        <= r_ptr + 16'd1;
                            r_phase_done <= 1'b1;
                        end
                        if (w_byte_end) r_shift <= rd_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_o     = 1'b0;
    assign sda_t     = r_sda_t;
    assign wr_valid  = r_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_addr   = r_ptr;
    assign busy      = r_busy;
    assign state_out = r_state;

endmodule

// File: tb/tb_sccb_target.sv
// Bench for sccb_target: bus-level master, register-file stand-in and a
// transaction-level model of pointer and write behaviour.
`timescale 1ns/1ps
module tb_sccb_target;
    import sccb_pkg::*;

    localparam int         Q   = 6;      // clk_in cycles per quarter SCL period
    localparam logic [6:0] DEV = 7'h3C;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] data;
        logic [3:0] acks;
        logic       wr;
    } wvec_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        scl;
    logic        m_sda;
    wire         sda_bus;
    logic        sda_o, sda_t, wr_valid, busy;
    logic [15:0] wr_addr, rd_addr;
    logic [7:0]  wr_data, rd_data;
    logic [3:0]  state_out;

    always #5 clk_in = ~clk_in;
    assign sda_bus = m_sda & (sda_t | sda_o);

    sccb_target #(.DEVICE_ADDR(DEV), .SYNC_STAGES(2)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .scl_i     (scl),
        .sda_i     (sda_bus),
        .sda_o     (sda_o),
        .sda_t     (sda_t),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .state_out (state_out)
    );

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'hA5;
    endfunction

    // Register-file stand-in: unwritten locations return a fixed address hash.
    logic [7:0] rf     [0:65535];
    bit         rf_wr  [0:65535];
    always @(posedge clk_in) begin
        if (wr_valid) begin
            rf[wr_addr]    <= wr_data;
            rf_wr[wr_addr] <= 1'b1;
        end
        rd_data <= rf_wr[rd_addr] ? rf[rd_addr] : dflt(rd_addr);
    end

    wr_t obs_q[$];
    int  low_cnt  = 0;
    int  busy_cnt = 0;
    always @(negedge clk_in) begin
        if (wr_valid) obs_q.push_back('{wr_addr, wr_data});
        if (!sda_t)   low_cnt  <= low_cnt + 1;
        if (busy)     busy_cnt <= busy_cnt + 1;
    end

    // Transaction-level reference model.
    logic [15:0] m_ptr;
    logic [7:0]  m_mem [0:65535];
    bit          m_wr  [0:65535];
    wr_t         exp_q[$];

    function automatic logic [7:0] m_read(input logic [15:0] a);
        return m_wr[a] ? m_mem[a] : dflt(a);
    endfunction

    task automatic model_write(input logic [7:0] b[$]);
        logic [7:0] dev_byte;
        dev_byte = b[0];
        if (dev_byte != {DEV, 1'b0}) return;
        for (int i = 1; i < b.size(); i++) begin
            if (i == 1)      m_ptr[15:8] = b[i];
            else if (i == 2) m_ptr[7:0]  = b[i];
            else begin
                exp_q.push_back('{m_ptr, b[i]});
                m_mem[m_ptr] = b[i];
                m_wr[m_ptr]  = 1'b1;
                m_ptr        = m_ptr + 16'd1;
            end
        end
    endtask

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_writes(input string name);
        wr_t o, e;
        check({name, " write count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({name, " wr_addr"}, o.addr, e.addr);
            check({name, " wr_data"}, o.data, e.data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_wr(input string name, input logic [15:0] a, input logic [7:0] d);
        wr_t o;
        checks++;
        if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL %s: got no write expected %0h=%0h", name, a, d);
        end else begin
            o = obs_q.pop_front();
            check({name, " wr_addr"}, o.addr, a);
            check({name, " wr_data"}, o.data, d);
        end
    endtask

    // Bus master primitives; every step lands on a falling clk_in edge.
    task automatic qw();
        repeat (Q) @(negedge clk_in);
    endtask

    task automatic bus_start();
        m_sda = 1'b0; qw(); scl = 1'b0; qw();
    endtask

    task automatic bus_rstart();
        m_sda = 1'b1; qw(); scl = 1'b1; qw(); m_sda = 1'b0; qw(); scl = 1'b0; qw();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qw(); scl = 1'b1; qw(); m_sda = 1'b1; qw();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        m_sda = b; qw(); scl = 1'b1; qw(); s = sda_bus; qw(); scl = 1'b0; qw();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clock_bit(nack, s);
    endtask

    task automatic send_seq(input logic [7:0] b[$], output logic [7:0] acks);
        logic a;
        acks = '0;
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], a);
            acks[i] = a;
        end
    endtask

    task automatic do_write(input logic [7:0] b[$], output logic [7:0] acks);
        bus_start();
        send_seq(b, acks);
        bus_stop();
    endtask

    task automatic do_read(input int n, input string name);
        logic       a;
        logic [7:0] d, e;
        bus_start();
        send_byte({DEV, 1'b1}, a);
        check({name, " addr ack"}, a, 1'b1);
        for (int i = 0; i < n; i++) begin
            e = m_read(m_ptr);
            recv_byte(i == n - 1, d);
            check({name, " data"}, d, e);
            if (i < n - 1) m_ptr = m_ptr + 16'd1;
        end
        check({name, " released after nack"}, sda_t, 1'b1);
        bus_stop();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wvec_t       vecs [4];
        logic [7:0]  q[$];
        logic [7:0]  acks;
        logic [7:0]  d;
        logic        a, s;
        int          lc, bc;

        vecs[0] = '{8'h78, 8'h30, 8'h08, 8'h82, 4'b1111, 1'b1};
        vecs[1] = '{8'h42, 8'h30, 8'h08, 8'h82, 4'b0000, 1'b0};
        vecs[2] = '{8'h7A, 8'h12, 8'h34, 8'h56, 4'b0000, 1'b0};
        vecs[3] = '{8'h78, 8'h00, 8'h7F, 8'hC3, 4'b1111, 1'b1};

        rst_in = 1'b1;
        scl    = 1'b1;
        m_sda  = 1'b1;
        m_ptr  = '0;
        repeat (5) @(negedge clk_in);
        check("reset sda_t",     sda_t,     1'b1);
        check("reset wr_valid",  wr_valid,  1'b0);
        check("reset wr_addr",   wr_addr,   16'h0);
        check("reset wr_data",   wr_data,   8'h0);
        check("reset rd_addr",   rd_addr,   16'h0);
        check("reset busy",      busy,      1'b0);
        check("reset state",     state_out, IDLE);
        check("sda_o constant",  sda_o,     1'b0);
        rst_in = 1'b0;
        qw();

        // Table of single-register writes, matching and non-matching.
        foreach (vecs[k]) begin
            q  = '{vecs[k].dev, vecs[k].hi, vecs[k].lo, vecs[k].data};
            lc = low_cnt;
            bc = busy_cnt;
            do_write(q, acks);
            model_write(q);
            exp_q.delete();
            check($sformatf("vec%0d acks", k), acks[3:0], vecs[k].acks);
            check($sformatf("vec%0d busy seen", k), busy_cnt != bc, vecs[k].wr);
            check($sformatf("vec%0d busy after stop", k), busy, 1'b0);
            if (vecs[k].wr) check_wr($sformatf("vec%0d", k), {vecs[k].hi, vecs[k].lo}, vecs[k].data);
            else            check($sformatf("vec%0d sda never low", k), low_cnt - lc, 0);
            check($sformatf("vec%0d no extra writes", k), obs_q.size(), 0);
            obs_q.delete();
        end

        // Burst write with auto-increment.
        q = '{8'h78, 8'h38, 8'h00, 8'h11, 8'h22, 8'h33};
        do_write(q, acks);
        model_write(q);
        exp_q.delete();
        check("burst acks", acks, 8'h3F);
        check_wr("burst 0", 16'h3800, 8'h11);
        check_wr("burst 1", 16'h3801, 8'h22);
        check_wr("burst 2", 16'h3802, 8'h33);
        check("burst pointer", rd_addr, 16'h3803);

        // Random-read: preload, set pointer with an address-only write, then read.
        q = '{8'h78, 8'h30, 8'h0A, 8'h56, 8'h40};
        do_write(q, acks);
        model_write(q);
        check_writes("preload");
        q = '{8'h78, 8'h30, 8'h0A};
        do_write(q, acks);
        model_write(q);
        check("ptr set acks", acks, 8'h07);
        check("ptr set pointer", rd_addr, 16'h300A);
        bus_start();
        send_byte(8'h79, a);
        check("rd addr ack", a, 1'b1);
        recv_byte(1'b0, d);
        check("rd byte0", d, 8'h56);
        recv_byte(1'b1, d);
        check("rd byte1", d, 8'h40);
        check("rd released after nack", sda_t, 1'b1);
        bus_stop();
        m_ptr = m_ptr + 16'd1;
        check("rd no writes", obs_q.size(), 0);
        check("rd pointer", rd_addr, 16'h300B);

        // Repeated START part-way through REG_LO, then a wrapping burst.
        bus_start();
        q = '{8'h78, 8'h12};
        send_seq(q, acks);
        model_write(q);
        for (int i = 0; i < 3; i++) clock_bit(1'b1, s);
        bus_rstart();
        q = '{8'h78, 8'hFF, 8'hFF, 8'hA1, 8'hB2};
        send_seq(q, acks);
        bus_stop();
        model_write(q);
        exp_q.delete();
        check("rstart acks", acks, 8'h1F);
        check_wr("wrap 0", 16'hFFFF, 8'hA1);
        check_wr("wrap 1", 16'h0000, 8'hB2);
        check("wrap no extra", obs_q.size(), 0);
        check("wrap pointer", rd_addr, 16'h0001);

        // Reset while the target holds the address ACK low.
        bus_start();
        for (int i = 7; i >= 0; i--) clock_bit(q[0][i], s);
        check("ack driven pre-reset", sda_t, 1'b0);
        check("busy pre-reset", busy, 1'b1);
        rst_in = 1'b1;
        #1;
        check("reset releases sda", sda_t, 1'b0 ^ 1'b1);
        check("reset clears busy", busy, 1'b0);
        m_ptr = '0;
        repeat (3) @(negedge clk_in);
        scl   = 1'b1;
        m_sda = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        qw();
        q = '{8'h78, 8'h12, 8'h34, 8'h56};
        do_write(q, acks);
        model_write(q);
        check("post-reset acks", acks, 8'h0F);
        check_writes("post-reset");

        // Randomized transactions against the model.
        for (int it = 0; it < 16; it++) begin
            logic [6:0] ra;
            int         kind, nd;
            kind = $urandom_range(0, 4);
            if (kind == 4) begin
                do_read($urandom_range(1, 3), $sformatf("rand%0d read", it));
            end else begin
                q.delete();
                ra = 7'($urandom);
                if (ra == DEV) ra = ra + 7'd1;
                q.push_back(kind == 0 ? {ra, 1'b0} : {DEV, 1'b0});
                q.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                if ($urandom_range(0, 5) != 0) begin
                    q.push_back(($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom));
                    nd = $urandom_range(0, 3);
                    for (int j = 0; j < nd; j++) q.push_back(8'($urandom));
                end
                do_write(q, acks);
                model_write(q);
                check($sformatf("rand%0d acks", it), acks,
                      (kind == 0) ? 8'h00 : 8'((1 << q.size()) - 1));
                check_writes($sformatf("rand%0d", it));
            end
            check($sformatf("rand%0d pointer", it), rd_addr, m_ptr);
            check($sformatf("rand%0d busy idle", it), busy, 1'b0);
        end

        check("final state", state_out, IDLE);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
